keccak_obi_ctrl: RTL and testbench

Memory-mapped front-end for the Keccak-f[1600] accelerator, attached as the single slave behind the external bus crossbar in the Keccak address window (1 MiB at `EXT_SLAVE_START_ADDRESS`). It accepts OBI requests from the crossbar and buffers the 1600-bit input state as 50 × 32-bit words. It launches and tracks one permutation on the Keccak core, captures the result for read-back, and raises a completion interrupt.

---
 rtl/keccak_obi_ctrl.sv | 152 +++++++++++++++
 tb/tb_keccak_obi_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_obi_ctrl.sv
// OBI slave front-end for the Keccak-f[1600] core: buffers the input state,
// launches one permutation at a time, captures the result and flags completion.
module keccak_obi_ctrl #(
  parameter int NWORDS = 50
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic                   we_i,
  input  logic [3:0]             be_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  output logic                   rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   keccak_start_o,
  output logic [NWORDS*32-1:0]   keccak_din_o,
  input  logic [NWORDS*32-1:0]   keccak_dout_i,
  input  logic                   keccak_done_i,
  output logic                   irq_o
);

  localparam int         SW        = NWORDS * 32;
  localparam logic [6:0] NWORDS_W  = 7'(NWORDS);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [SW-1:0]     din_r;
  logic [SW-1:0]     dout_r;
  logic              done_r;
  logic              start_r;
  logic              rvalid_r;
  logic [31:0]       rdata_r;
  logic [31:0]       rdata_s;
  logic [31:0]       din_word_s;
  logic [31:0]       dout_word_s;
  logic [NWORDS-1:0] word_sel_s;
  logic [11:0]       offset_s;
  logic [6:0]        word_idx_s;
  logic              din_hit_s;
  logic              dout_hit_s;
  logic              ctrl_hit_s;
  logic              status_hit_s;
  logic              wr_s;
  logic              rd_s;
  logic              busy_s;
  logic              start_go_s;
  logic              clr_s;
  logic              capture_s;
  logic              din_wr_s;
  logic              unused_addr_s;

  // Only the low 12 address bits decode; the map aliases across the window.
  assign offset_s      = addr_i[11:0];
  assign word_idx_s    = offset_s[8:2];
  assign din_hit_s     = (offset_s[11:9] == 3'b000) && (word_idx_s < NWORDS_W);
  assign dout_hit_s    = (offset_s[11:9] == 3'b001) && (word_idx_s < NWORDS_W);
  assign ctrl_hit_s    = (offset_s == 12'h400);
  assign status_hit_s  = (offset_s == 12'h404);
  assign unused_addr_s = ^{addr_i[31:12], addr_i[1:0]};

  assign wr_s       = req_i & we_i;
  assign rd_s       = req_i & ~we_i;
  assign busy_s     = (state_r != ST_IDLE);
  assign start_go_s = wr_s & ctrl_hit_s & wdata_i[0] & ~busy_s;
  assign clr_s      = wr_s & ctrl_hit_s & wdata_i[1];
  assign capture_s  = (state_r == ST_BUSY) & keccak_done_i;
  // DIN is frozen from START until the result is captured.
  assign din_wr_s   = wr_s & din_hit_s & ~busy_s;

  // Word select and read-side word muxes for DIN and DOUT.
  always_comb begin
    word_sel_s  = {NWORDS{1'b0}};
    din_word_s  = 32'h0000_0000;
    dout_word_s = 32'h0000_0000;
    for (int k = 0; k < NWORDS; k++) begin
      word_sel_s[k] = (word_idx_s == 7'(k));
      din_word_s    = din_word_s  | (din_r[32*k +: 32]  & {32{word_sel_s[k]}});
      dout_word_s   = dout_word_s | (dout_r[32*k +: 32] & {32{word_sel_s[k]}});
    end
  end

  // Read data for the response phase; writes and unmapped reads return zero.
  always_comb begin
    if (!rd_s) begin
      rdata_s = 32'h0000_0000;
    end else if (status_hit_s) begin
      rdata_s = {30'h0000_0000, busy_s, done_r};
    end else if (din_hit_s) begin
      rdata_s = din_word_s;
    end else if (dout_hit_s) begin
      rdata_s = dout_word_s;
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Permutation control FSM next state.
  always_comb begin
    case (state_r)
      ST_IDLE:  state_nxt_s = start_go_s ? ST_START : ST_IDLE;
      ST_START: state_nxt_s = ST_BUSY;
      ST_BUSY:  state_nxt_s = keccak_done_i ? ST_IDLE : ST_BUSY;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State, register file, result capture and bus response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      din_r    <= {SW{1'b0}};
      dout_r   <= {SW{1'b0}};
      done_r   <= 1'b0;
      start_r  <= 1'b0;
      rvalid_r <= 1'b0;
      rdata_r  <= 32'h0000_0000;
    end else begin
      state_r  <= state_nxt_s;
      start_r  <= (state_nxt_s == ST_START);
      rvalid_r <= req_i;
      rdata_r  <= rdata_s;
      // A capture beats a same-cycle CLR_DONE, so the completion is never lost.
      if (capture_s) begin
        dout_r <= keccak_dout_i;
        done_r <= 1'b1;
      end else if (start_go_s || clr_s) begin
        done_r <= 1'b0;
      end else begin
        done_r <= done_r;
      end
      for (int k = 0; k < NWORDS; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (din_wr_s && word_sel_s[k] && be_i[b]) begin
            din_r[32*k + 8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  assign gnt_o          = req_i;
  assign rvalid_o       = rvalid_r;
  assign rdata_o        = rdata_r;
  assign keccak_start_o = start_r;
  assign keccak_din_o   = din_r;
  assign irq_o          = done_r;

endmodule

// File: tb/tb_keccak_obi_ctrl.sv
// Bench for keccak_obi_ctrl: directed test-plan steps followed by random bus
// traffic, all checked against a word-level model of the register map.
module tb_keccak_obi_ctrl;
  localparam int NW = 50;

  logic             clk = 1'b0;
  logic             rst, req, gnt, we, rvalid, kstart, kdone, irq;
  logic [3:0]       be;
  logic [31:0]      addr, wdata, rdata;
  logic [NW*32-1:0] kdin, kdout;

  int checks = 0;
  int failures = 0;

  logic [31:0] din_m [NW];
  logic [31:0] dout_m[NW];
  bit          done_m, busy_m, start_due_m;
  logic [31:0] rv;

  always #5 clk = ~clk;

  keccak_obi_ctrl #(.NWORDS(NW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
    .keccak_start_o(kstart), .keccak_din_o(kdin), .keccak_dout_i(kdout),
    .keccak_done_i(kdone), .irq_o(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_din();
    logic [NW*32-1:0] expv;
    int bad;
    for (int k = 0; k < NW; k++) expv[32*k +: 32] = din_m[k];
    checks++;
    assert (kdin === expv) else begin
      failures++;
      bad = 0;
      for (int k = NW - 1; k >= 0; k--) if (kdin[32*k +: 32] !== expv[32*k +: 32]) bad = k;
      $error("FAIL din_o word=%0d observed=%h expected=%h", bad, kdin[32*bad +: 32], expv[32*bad +: 32]);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int o;
    o = int'(a & 32'h0000_0FFF);
    if (o == 32'h404) return {30'd0, busy_m, done_m};
    if (o < 32'h0C8) return din_m[o / 4];
    if (o >= 32'h200 && o < 32'h2C8) return dout_m[(o - 32'h200) / 4];
    return 32'h0;
  endfunction

  // One bus cycle: drive, update the model, step the clock, check everything.
  task automatic cyc(input bit r, input bit w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, input bit dn, output logic [31:0] rd_out);
    logic [31:0] expd;
    bit cap, nstart;
    int o;
    expd = (r && !w) ? exp_read(a) : 32'h0;
    req = r; we = w; be = b; addr = a; wdata = d; kdone = dn;
    #1;
    chk("gnt", {31'd0, gnt}, {31'd0, r});
    cap = dn && busy_m && !start_due_m;
    nstart = 1'b0;
    o = int'(a & 32'h0000_0FFF);
    if (r && w) begin
      if (o < 32'h0C8 && !busy_m)
        for (int i = 0; i < 4; i++) if (b[i]) din_m[o / 4][8*i +: 8] = d[8*i +: 8];
      if (o == 32'h400) begin
        if (d[1]) done_m = 1'b0;
        if (d[0] && !busy_m) begin
          busy_m = 1'b1;
          nstart = 1'b1;
          done_m = 1'b0;
        end
      end
    end
    if (cap) begin
      for (int k = 0; k < NW; k++) dout_m[k] = kdout[32*k +: 32];
      done_m = 1'b1;
      busy_m = 1'b0;
    end
    start_due_m = nstart;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; kdone = 1'b0;
    chk("rvalid", {31'd0, rvalid}, {31'd0, r});
    if (r) chk(w ? "rdata_wr" : "rdata_rd", rdata, expd);
    chk("start", {31'd0, kstart}, {31'd0, start_due_m});
    chk("irq", {31'd0, irq}, {31'd0, done_m});
    chk_din();
    rd_out = rdata;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] t;
    cyc(1'b1, 1'b1, b, a, d, 1'b0, t);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    cyc(1'b1, 1'b0, 4'hF, a, 32'h0, 1'b0, d);
  endtask

  task automatic idle(input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, t);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; kdone = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NW; k++) begin
      din_m[k] = 32'h0;
      dout_m[k] = 32'h0;
    end
    done_m = 1'b0; busy_m = 1'b0; start_due_m = 1'b0;
    chk("rst_rvalid", {31'd0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_start", {31'd0, kstart}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    chk("rst_gnt", {31'd0, gnt}, 32'h0);
    chk_din();
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    kdone = 1'b0; kdout = '0;

    // Reset
    do_reset();
    rd(32'h0000_0404, rv); chk("rst_status", rv, 32'h0);
    rd(32'h0000_0000, rv); chk("rst_din0", rv, 32'h0);

    // Byte-enable write
    wr(32'h0000_000C, 32'hDEAD_BEEF, 4'b0101);
    rd(32'h0000_000C, rv); chk("be_read", rv, 32'h00AD_00EF);
    chk("be_din_o", kdin[127:96], 32'h00AD_00EF);

    // Full run
    for (int k = 0; k < NW; k++) wr(32'(4 * k), 32'(k + 1), 4'hF);
    for (int k = 0; k < NW; k++) kdout[32*k +: 32] = ~32'(k);
    wr(32'h0000_0400, 32'h1, 4'hF);
    chk("start_pulse", {31'd0, kstart}, 32'h1);
    idle(1);
    chk("start_single", {31'd0, kstart}, 32'h0);
    rd(32'h0000_0404, rv); chk("status_busy", rv, 32'h2);
    // Stability while busy
    wr(32'h0000_0000, 32'h1234_5678, 4'hF);
    wr(32'h0000_0400, 32'h1, 4'hF);
    chk("din_stable", kdin[31:0], 32'h1);
    chk("no_restart", {31'd0, kstart}, 32'h0);
    // STATUS read colliding with done returns pre-capture value
    cyc(1'b1, 1'b0, 4'hF, 32'h0000_0404, 32'h0, 1'b1, rv);
    chk("status_collide", rv, 32'h2);
    chk("irq_after_done", {31'd0, irq}, 32'h1);
    rd(32'h0000_0404, rv); chk("status_done", rv, 32'h1);
    rd(32'h0000_02C4, rv); chk("dout49", rv, 32'hFFFF_FFCE);

    // Clear and collision
    wr(32'h0000_0400, 32'h2, 4'hF);
    chk("irq_cleared", {31'd0, irq}, 32'h0);
    wr(32'h0000_0400, 32'h1, 4'hF);
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, rv);  // done during START is ignored
    rd(32'h0000_0404, rv); chk("status_start_done", rv, 32'h2);
    cyc(1'b1, 1'b1, 4'hF, 32'h0000_0400, 32'h2, 1'b1, rv);
    chk("clr_collide_irq", {31'd0, irq}, 32'h1);
    rd(32'h0000_0404, rv); chk("clr_collide_status", rv, 32'h1);
    // START with CLR_DONE together leaves DONE clear
    wr(32'h0000_0400, 32'h3, 4'hF);
    rd(32'h0000_0404, rv); chk("start_clr", rv, 32'h2);
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, rv);

    // Unmapped and alias
    rd(32'h0000_0600, rv); chk("unmapped", rv, 32'h0);
    wr(32'h0000_1000, 32'hA5A5_5A5A, 4'hF);
    rd(32'h0000_0000, rv); chk("alias_din0", rv, 32'hA5A5_5A5A);
    rd(32'hF00A_3404, rv); chk("alias_status", rv, 32'h1);

    // Abort with reset in BUSY
    wr(32'h0000_0400, 32'h1, 4'hF);
    idle(2);
    do_reset();
    for (int k = 0; k < NW; k++) kdout[32*k +: 32] = $urandom;
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, rv);
    rd(32'h0000_0404, rv); chk("abort_status", rv, 32'h0);
    rd(32'h0000_0200, rv); chk("abort_dout0", rv, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int sel;
      logic [31:0] a, d;
      logic [3:0] b;
      bit dn;
      sel = $urandom_range(0, 9);
      d = $urandom;
      b = 4'($urandom_range(0, 15));
      dn = ($urandom_range(0, 7) == 0);
      if (dn) for (int k = 0; k < NW; k++) kdout[32*k +: 32] = $urandom;
      a = $urandom & 32'hFFFF_F000;
      case (sel)
        0, 1, 2: a = a | (32'($urandom_range(0, NW - 1)) * 32'd4);
        3, 4:    a = a | 32'h200 | (32'($urandom_range(0, NW - 1)) * 32'd4);
        5:       a = a | 32'h404;
        6:       begin a = a | 32'h400; d = d & 32'h3; end
        7:       a = a | (32'($urandom_range(0, 1023)) * 32'd4);
        default: a = a;
      endcase
      if (sel == 9) cyc(1'b0, 1'b0, 4'h0, a, d, dn, rv);
      else cyc(1'b1, ($urandom_range(0, 1) == 1) || (sel == 6), b, a, d, dn, rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
